// File: rtl/audio_pkg.sv
// Shared audio constants and types for the voice bank output path.
// Frame layout helpers used by the I2S serializer.
package audio_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int SLOT_W          = 32;
    localparam int SLOTS_PER_FRAME = 2;
    localparam int FRAME_BITS      = SLOT_W * SLOTS_PER_FRAME;
    localparam int BIT_W           = $clog2(FRAME_BITS);

    localparam int FCLK_HZ = 147456000;
    localparam int FS_HZ   = 48000;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Same sample in both slots, left-justified, zero padded.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input sample_t s);
        return {s, {(SLOT_W - SAMPLE_W){1'b0}},
                s, {(SLOT_W - SAMPLE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S clock generator: divides clk147 into MCLK and BCLK, counts bits
// in the 64-bit frame and flags the BCLK falling edge and frame wrap.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 48,
    parameter int MCLK_DIV = 12
) (
    input  logic             clk147,
    input  logic             rst,
    output logic             mclk,
    output logic             bclk,
    output logic             lrclk,
    output logic             bit_edge,
    output logic             frame_edge,
    output logic [BIT_W-1:0] bit_nxt
);

    localparam int DIV_W = $clog2(BCLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [BIT_W-1:0] bit_cnt;

    // Next counter values; a bit edge is the cycle where div_cnt wraps.
    always_comb begin
        bit_edge   = (div_cnt == DIV_W'(BCLK_DIV - 1));
        frame_edge = bit_edge && (bit_cnt == {BIT_W{1'b1}});
        div_nxt    = bit_edge ? '0 : div_cnt + 1'b1;
        bit_nxt    = bit_edge ? bit_cnt + 1'b1 : bit_cnt;
    end

    // Counters and registered clock outputs so they never glitch.
    always_ff @(posedge clk147) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            mclk    <= 1'b0;
            lrclk   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            bclk    <= 32'(div_nxt) >= 32'(BCLK_DIV / 2);
            mclk    <= (32'(div_nxt) % 32'(MCLK_DIV)) >= 32'(MCLK_DIV / 2);
            if (bit_edge) begin
                lrclk <= bit_nxt[BIT_W-1];
            end
        end
    end

endmodule

// File: rtl/i2s_mix_out.sv
// Voice mixer and Philips I2S transmitter: sums all voices, scales,
// saturates, mutes and serializes one mono sample per frame.
module i2s_mix_out
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int MIX_SHIFT  = 3,
    parameter int BCLK_DIV   = 48,
    parameter int MCLK_DIV   = 12
) (
    input  logic                           clk147,
    input  logic                           rst,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic                           mute,
    output logic                           sample_strobe,
    output logic                           mclk,
    output logic                           bclk,
    output logic                           lrclk,
    output logic                           sdata,
    output logic                           clip
);

    localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);

    localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'(32'sd32767);
    localparam logic signed [SUM_W-1:0] S_MIN = SUM_W'(-32'sd32768);

    logic                    bit_edge;
    logic                    frame_edge;
    logic [BIT_W-1:0]        bit_nxt;
    logic [BIT_W-1:0]        sidx;

    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] shifted;
    sample_t                 mix_d;
    sample_t                 mix_q;
    logic                    sat_d;
    logic                    sat_q;
    sample_t                 cap_s;
    logic [FRAME_BITS-1:0]   frame_d;
    logic [FRAME_BITS-1:0]   frame_q;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV),
        .MCLK_DIV (MCLK_DIV)
    ) u_clkgen (
        .clk147     (clk147),
        .rst        (rst),
        .mclk       (mclk),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .bit_edge   (bit_edge),
        .frame_edge (frame_edge),
        .bit_nxt    (bit_nxt)
    );

    // Full-width signed sum of every voice; wide enough to never wrap.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum_d = sum_d
                  + SUM_W'($signed(voice_samples[SAMPLE_W*i +: SAMPLE_W]));
        end
    end

    // Scale down and clamp to the 16-bit range, flagging clipping.
    always_comb begin
        shifted = sum_q >>> MIX_SHIFT;
        sat_d   = 1'b1;
        if (shifted > S_MAX) begin
            mix_d = 16'sh7fff;
        end else if (shifted < S_MIN) begin
            mix_d = 16'sh8000;
        end else begin
            sat_d = 1'b0;
            mix_d = shifted[SAMPLE_W-1:0];
        end
    end

    // Frame capture and serializer bit select for the upcoming bit.
    always_comb begin
        cap_s   = mute ? '0 : mix_q;
        frame_d = frame_edge ? pack_frame(cap_s) : frame_q;
        sidx    = '0 - bit_nxt;
    end

    // Mix pipeline, frame register and registered I2S data outputs.
    always_ff @(posedge clk147) begin
        if (rst) begin
            sum_q         <= '0;
            mix_q         <= '0;
            sat_q         <= 1'b0;
            frame_q       <= '0;
            sdata         <= 1'b0;
            sample_strobe <= 1'b0;
            clip          <= 1'b0;
        end else begin
            sum_q         <= sum_d;
            mix_q         <= mix_d;
            sat_q         <= sat_d;
            frame_q       <= frame_d;
            sample_strobe <= frame_edge;
            clip          <= frame_edge & sat_q & ~mute;
            if (bit_edge) begin
                sdata <= frame_d[sidx];
            end
        end
    end

endmodule

// File: tb/tb_i2s_mix_out.sv
// Bench for i2s_mix_out: frame-level reference model compared every
// cycle, plus I2S receiver decode and hand-computed expectations.
module tb_i2s_mix_out;

    localparam int NV    = 8;
    localparam int BDIV  = 48;
    localparam int MDIV  = 12;
    localparam int FRAME = 64 * BDIV;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mute = 1'b0;
    logic [NV*16-1:0] voices = '0;

    logic st3, mc3, bc3, lr3, sd3, cl3;
    logic st0, mc0, bc0, lr0, sd0, cl0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2s_mix_out #(
        .NUM_VOICES (NV), .MIX_SHIFT (3),
        .BCLK_DIV (BDIV), .MCLK_DIV (MDIV)
    ) dut (
        .clk147 (clk), .rst (rst), .voice_samples (voices), .mute (mute),
        .sample_strobe (st3), .mclk (mc3), .bclk (bc3), .lrclk (lr3),
        .sdata (sd3), .clip (cl3)
    );

    i2s_mix_out #(
        .NUM_VOICES (NV), .MIX_SHIFT (0),
        .BCLK_DIV (BDIV), .MCLK_DIV (MDIV)
    ) dut0 (
        .clk147 (clk), .rst (rst), .voice_samples (voices), .mute (mute),
        .sample_strobe (st0), .mclk (mc0), .bclk (bc0), .lrclk (lr0),
        .sdata (sd0), .clip (cl0)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int raw_mix(input int shift);
        int s = 0;
        for (int i = 0; i < NV; i++) s += $signed(voices[16*i +: 16]);
        return s >>> shift;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [63:0] frm(input int v);
        logic [15:0] s = v[15:0];
        return {s, 16'h0, s, 16'h0};
    endfunction

    int          t = 0;
    bit          mvalid = 0;
    logic [63:0] f3 = '0, f0 = '0;
    bit          ex_st = 0, ex_c3 = 0, ex_c0 = 0;

    always @(posedge clk) begin
        int r3, r0;
        if (rst) begin
            t = 0; f3 = '0; f0 = '0;
            ex_st = 0; ex_c3 = 0; ex_c0 = 0;
            mvalid = 1;
        end else begin
            t++;
            ex_st = (t % FRAME == 0);
            ex_c3 = 0; ex_c0 = 0;
            if (ex_st) begin
                r3 = raw_mix(3);
                r0 = raw_mix(0);
                f3 = mute ? 64'h0 : frm(clamp16(r3));
                f0 = mute ? 64'h0 : frm(clamp16(r0));
                ex_c3 = !mute && (r3 != clamp16(r3));
                ex_c0 = !mute && (r0 != clamp16(r0));
            end
        end
    end

    function automatic logic [5:0] expv(input logic [63:0] f, input bit c);
        int d = t % BDIV;
        int n = (t / BDIV) % 64;
        return {ex_st, c, (d % MDIV) >= MDIV/2, d >= BDIV/2, n >= 32,
                f[(64 - n) % 64]};
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_s3", {st3, cl3, mc3, bc3, lr3, sd3}, expv(f3, ex_c3));
            chk("model_s0", {st0, cl0, mc0, bc0, lr0, sd0}, expv(f0, ex_c0));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_strobe(output int cyc);
        @(negedge clk);
        cyc = 1;
        while (!st3 && cyc < 2 * FRAME) begin
            @(negedge clk);
            cyc++;
        end
        if (!st3) chk("strobe_timeout", 64'd0, 64'd1);
    endtask

    task automatic rx_frame(input string nm, input logic [15:0] es,
                            input int mb, input bit mv);
        logic [15:0] l = '0, r = '0;
        int ferr = 0;
        for (int n = 0; n < 64; n++) begin
            repeat (BDIV/2) @(negedge clk);
            if (n == mb) mute = mv;
            if (lr3 !== (n >= 32)) ferr++;
            if (n >= 1 && n <= 16) l[16-n] = sd3;
            else if (n >= 33 && n <= 48) r[48-n] = sd3;
            else if (sd3 !== 1'b0) ferr++;
            repeat (BDIV/2) @(negedge clk);
        end
        chk({nm, "_left"}, l, es);
        chk({nm, "_right"}, r, es);
        chk({nm, "_framing"}, ferr, 0);
        chk({nm, "_frame_len"}, st3, 1);
    endtask

    task automatic step(input string nm, input bit c3, input bit c0,
                        input logic [NV*16-1:0] nv, input logic [15:0] es,
                        input int mb, input bit mv);
        chk({nm, "_clip3"}, cl3, c3);
        chk({nm, "_clip0"}, cl0, c0);
        voices = nv;
        rx_frame(nm, es, mb, mv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, bhi, brise, mrise, lrlo, sdhi, first, total;
        logic pb, pm;
        logic [NV*16-1:0] v12, vmax, vmin;
        v12  = '0;
        v12[15:0]  = 16'd1000;
        v12[31:16] = 16'd2000;
        vmax = {NV{16'h7fff}};
        vmin = {NV{16'h8000}};

        repeat (3) @(negedge clk);
        chk("reset_out", {st3, cl3, mc3, bc3, lr3, sd3}, 0);
        rst = 0;

        bhi = 0; brise = 0; mrise = 0; lrlo = 0; sdhi = 0; first = 0;
        pb = 0; pm = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            bhi   += bc3;
            brise += (bc3 && !pb);
            mrise += (mc3 && !pm);
            lrlo  += !lr3;
            sdhi  += sd3;
            if (st3 && first == 0) first = k;
            pb = bc3; pm = mc3;
        end
        chk("first_strobe", first, FRAME);
        chk("bclk_high", bhi, 1536);
        chk("bclk_periods", brise, 64);
        chk("mclk_periods", mrise, 256);
        chk("lrclk_low", lrlo, 1536);
        chk("idle_sdata", sdhi, 0);

        step("zero", 0, 0, v12,  16'h0000, -1, 0);
        step("v12",  0, 0, vmax, 16'h0177, -1, 0);
        step("pos",  0, 1, vmin, 16'h7fff, -1, 0);
        step("neg",  0, 1, vmax, 16'h8000, -1, 0);
        step("mute", 0, 1, vmax, 16'h7fff, 20, 1);
        step("mutd", 0, 0, vmax, 16'h0000, 10, 0);
        chk("unmute_clip0", cl0, 1);

        repeat (20 * BDIV + 5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_s3", {st3, cl3, mc3, bc3, lr3, sd3}, 0);
        chk("midrst_s0", {st0, cl0, mc0, bc0, lr0, sd0}, 0);
        rst = 0;
        wait_strobe(cyc);
        chk("rst_strobe", cyc, FRAME);
        chk("rst_clip0", cl0, 1);

        total = 0;
        for (int f = 0; f < 8; f++) begin
            int mc;
            for (int i = 0; i < NV; i++) begin
                case ($urandom_range(0, 5))
                    0: voices[16*i +: 16] = 16'h7fff;
                    1: voices[16*i +: 16] = 16'h8000;
                    default: voices[16*i +: 16] = 16'($urandom);
                endcase
            end
            mc = $urandom_range(200, 2800);
            repeat (mc) @(negedge clk);
            mute = ($urandom_range(0, 3) == 0);
            wait_strobe(cyc);
            total += mc + cyc;
        end
        chk("strobe_rate", total, 8 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_mix_out.md
Name: i2s_mix_out

Overview:
- Downstream stage of the voice bank.
- Sums the signed 16-bit outputs of all voices, then scales, saturates and mutes the sum.
- Captures one mixed sample per audio frame and serializes it to the DAC as standard Philips I2S, with the same sample on left and right.
- Generates MCLK, BCLK and LRCLK from clk147 (147.456 MHz), plus a per-frame sample_strobe that voices and control logic use as their sample tick.

Parameters:
- NUM_VOICES, 8: number of voice sample inputs (1..16).
- MIX_SHIFT, 3: arithmetic right shift applied to the raw sum before saturation.
- BCLK_DIV, 48: clk147 cycles per BCLK period; must be even. 48 gives BCLK 3.072 MHz and fs 48 kHz.
- MCLK_DIV, 12: clk147 cycles per MCLK period; must be even and divide BCLK_DIV. 12 gives 12.288 MHz (256 fs).

Ports:
- clk147  in  1  system clock, 147.456 MHz
- rst  in  1  synchronous, active-high reset
- voice_samples  in  NUM_VOICES*16  packed signed samples; voice i occupies bits [16i+15:16i]
- mute  in  1  forces captured sample to 0
- sample_strobe  out  1  one-cycle pulse at each frame capture
- mclk  out  1  DAC master clock
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select; 0 = left
- sdata  out  1  I2S serial data
- clip  out  1  one-cycle pulse when the captured sample was saturated

Behaviour:
- Interface: one clock, clk147; rst is synchronous and active-high. All state is updated on the rising edge of clk147.
- Reset values: every output is 0; div_cnt, bit_cnt, the frame shift register and the pipeline registers are all 0.
- Counters:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk = (div_cnt >= BCLK_DIV/2).
  - mclk = ((div_cnt mod MCLK_DIV) >= MCLK_DIV/2).
  - A "bit edge" is the clock where div_cnt wraps to 0 (BCLK falling edge).
  - bit_cnt counts 0..63 and advances on each bit edge.
- Mix pipeline (free-running, 2-cycle latency):
  - Stage 1: sum = sign-extended sum of all voices. Width is 16+clog2(NUM_VOICES), so no overflow is possible.
  - Stage 2: shifted = sum >>> MIX_SHIFT, then saturated to [-32768, 32767] into mix_q. The sat flag is registered alongside mix_q.
- Capture: on the bit edge where bit_cnt goes 63->0:
  - F[63:0] <= {S, 16'h0, S, 16'h0}, where S = mute ? 0 : mix_q.
  - sample_strobe = 1 for exactly that cycle.
  - clip = sat & ~mute for that same cycle.
- Serialization, updated at each bit edge (new bit_cnt = n):
  - lrclk = (n >= 32).
  - sdata = F[63 - ((n+63) mod 64)], i.e. the MSB of the left slot appears at n=1, one BCLK after the LRCLK edge, per I2S.
  - At n=0, sdata = F[0] (trailing zero). At n=32, sdata = F[32] (trailing zero).
  - lrclk and sdata are stable for the whole BCLK period.
- Frame length is 64*BCLK_DIV clk147 cycles (3072 at defaults).
- First capture after reset occurs 3072 cycles after rst deasserts. Until then sdata = 0.
- Reset mid-frame: all counters and F clear on the next edge and the frame restarts from bit 0. No partial word resumes.
- mute changing mid-frame takes effect only at the next capture.
- Voice sample changes within 2 cycles of a capture edge may or may not be included. Voices update on sample_strobe, so the value is stable long before the next capture.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W=16, SLOT_W=32, SLOTS_PER_FRAME=2.
  - typedef logic signed [15:0] sample_t.
  - Constants FCLK_HZ=147456000 and FS_HZ=48000.
- One natural sub-module: i2s_clkgen. It owns div_cnt and bit_cnt and generates mclk, bclk, lrclk, bit_edge and frame_edge.
- The mixer and serializer stay in the top level.

Test Plan:
- Reset then idle with all voices 0: bclk period is 48 cycles at 50% duty; mclk period is 12; lrclk period is 3072 with low = 1536 cycles; sdata stays 0; the first sample_strobe is at cycle 3072.
- Voices = {1000, 2000, 0...} at MIX_SHIFT=3: S = 375 = 16'h0177. Decoded left = right = 16'h0177, MSB at bit 1 of each slot, slot bits 16..31 are 0, clip = 0.
- All 8 voices = 32767: sum 262136 >>> 3 = 32767, no clip. Then set MIX_SHIFT=0: S = 32767 and clip pulses once per frame. All voices = -32768 with MIX_SHIFT=0 gives S = -32768 and clip pulses.
- mute asserted mid-frame with voices nonzero: the current frame still carries the old sample; the next captured frame is all zero; clip stays 0.
- rst pulsed at bit_cnt=20: on the next cycle all outputs are 0; the next sample_strobe arrives exactly 3072 cycles after rst deasserts.
- sample_strobe count over 1 simulated second at 147.456 MHz is exactly 48000. An I2S receiver model reports no framing errors.
